start_button_conditioner: RTL and testbench

Conditions the raw ZCU104 pushbutton before it reaches the traffic-light controller's `start` input. The block synchronises the asynchronous pin, debounces it with a counter-based state machine and emits exactly one single-cycle `start_pulse` per accepted press. It also exports the debounced level and an optional long-press pulse. It sits directly upstream of the top-level FSM and drives its `start` input.

---
 rtl/tlc_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/start_button_conditioner.sv | 123 ++++++++++++
 tb/tb_start_button_conditioner.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared constants for the traffic-light controller: button debounce state encoding and
// default cycle counts for a 125 MHz system clock.
package tlc_pkg;

    localparam logic [1:0] BTN_IDLE         = 2'd0;
    localparam logic [1:0] BTN_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] BTN_PRESSED      = 2'd2;
    localparam logic [1:0] BTN_RELEASE_WAIT = 2'd3;

    typedef enum logic [1:0] {
        BtnIdle        = BTN_IDLE,
        BtnPressWait   = BTN_PRESS_WAIT,
        BtnPressed     = BTN_PRESSED,
        BtnReleaseWait = BTN_RELEASE_WAIT
    } btn_state_e;

    localparam int unsigned TLC_DEBOUNCE_CYCLES = 1250000;   // 10 ms
    localparam int unsigned TLC_LONG_CYCLES     = 125000000; // 1 s

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs; both stages clear on synchronous reset.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/start_button_conditioner.sv
// Synchronises and debounces the start pushbutton, emitting one start_pulse per accepted press.
// Define START_BTN_LONG_PRESS_EN to build the long-press counter; otherwise long_press is 0.
module start_button_conditioner
    import tlc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = TLC_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = TLC_LONG_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic start_pulse,
    output logic btn_level,
    output logic long_press
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic          s2;
    btn_state_e    state;
    logic [CW-1:0] cnt;

    sync_2ff #(
        .WIDTH(1)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (btn_raw),
        .q    (s2)
    );

    // Outputs are registered alongside the state so they change on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BtnIdle;
            cnt         <= '0;
            start_pulse <= 1'b0;
            btn_level   <= 1'b0;
        end else begin
            start_pulse <= 1'b0;
            unique case (state)
                BtnIdle: begin
                    if (s2) begin
                        state <= BtnPressWait;
                        cnt   <= '0;
                    end
                end
                BtnPressWait: begin
                    if (!s2) begin
                        state <= BtnIdle;
                        cnt   <= '0;
                    end else if (cnt == CNT_TERM) begin
                        state       <= BtnPressed;
                        start_pulse <= 1'b1;
                        btn_level   <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                BtnPressed: begin
                    if (!s2) begin
                        state <= BtnReleaseWait;
                        cnt   <= '0;
                    end
                end
                BtnReleaseWait: begin
                    // A bounce back high returns to PRESSED without a fresh start_pulse.
                    if (s2) begin
                        state <= BtnPressed;
                    end else if (cnt == CNT_TERM) begin
                        state     <= BtnIdle;
                        cnt       <= '0;
                        btn_level <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state     <= BtnIdle;
                    cnt       <= '0;
                    btn_level <= 1'b0;
                end
            endcase
        end
    end

`ifdef START_BTN_LONG_PRESS_EN
    localparam int unsigned LW = cnt_width(LONG_CYCLES);
    localparam logic [LW-1:0] LONG_TERM = LW'(LONG_CYCLES - 1);
    localparam logic [LW-1:0] LONG_PRE  = LW'(LONG_CYCLES - 2);

    logic          accept;
    logic          to_idle;
    logic          held;
    logic [LW-1:0] lcnt;

    assign accept  = (state == BtnPressWait) && s2 && (cnt == CNT_TERM);
    assign to_idle = (state == BtnReleaseWait) && !s2 && (cnt == CNT_TERM);
    assign held    = (state == BtnPressed) || (state == BtnReleaseWait);

    // Saturation at LONG_TERM guarantees at most one long_press per accepted press.
    always_ff @(posedge clk) begin
        if (reset) begin
            lcnt       <= '0;
            long_press <= 1'b0;
        end else begin
            long_press <= 1'b0;
            if (accept || to_idle) begin
                lcnt <= '0;
            end else if (held && (lcnt != LONG_TERM)) begin
                lcnt <= lcnt + LW'(1);
                if (lcnt == LONG_PRE) begin
                    long_press <= 1'b1;
                end
            end
        end
    end
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_start_button_conditioner.sv
// Scoreboard bench for start_button_conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=10.
module tb_start_button_conditioner;

    localparam int D = 4;
    localparam int L = 10;

    logic clk = 1'b0;
    logic reset;
    logic btn_raw;
    logic start_pulse;
    logic btn_level;
    logic long_press;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int start_q[$];
    int long_q[$];

    start_button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES    (L)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .start_pulse(start_pulse),
        .btn_level  (btn_level),
        .long_press (long_press)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulses are popped against their expected cycle; any unexpected pulse is a failure.
    always @(negedge clk) begin
        if (start_pulse !== 1'b0) begin
            if (start_q.size() == 0) check_eq("start_unexpected", cyc, 32'hffff_ffff);
            else check_eq("start_cycle", cyc, start_q.pop_front());
        end
        if (long_press !== 1'b0) begin
            if (long_q.size() == 0) check_eq("long_unexpected", cyc, 32'hffff_ffff);
            else check_eq("long_cycle", cyc, long_q.pop_front());
        end
    end

    // Drive btn_raw high now for `hold` cycles (optionally with a release bounce), then release.
    task automatic press(input int hold, input bit bounce);
        int c;
        int p;
        int r;
        bit acc;
        c   = cyc;
        acc = (hold >= D + 1);
        p   = c + 3 + D;
        r   = c + hold + (bounce ? 7 : 0);
        if (acc) start_q.push_back(p);
`ifdef START_BTN_LONG_PRESS_EN
        if (acc && (p + L - 1 <= r + 2 + D)) long_q.push_back(p + L - 1);
`endif
        btn_raw = 1'b1;
        tick(hold);
        check_eq("level_end_hold", btn_level, (acc && hold >= 3 + D) ? 1 : 0);
        if (bounce) begin
            btn_raw = 1'b0;
            tick(2);
            btn_raw = 1'b1;
            tick(2);
            check_eq("level_bounce", btn_level, 1);
            tick(3);
        end
        btn_raw = 1'b0;
        tick(2 + D);
        check_eq("level_before_rel", btn_level, acc ? 1 : 0);
        tick(1);
        check_eq("level_after_rel", btn_level, 0);
    endtask

    initial begin
        reset   = 1'b1;
        btn_raw = 1'b1;
        tick(1);
        check_eq("rst_start", start_pulse, 0);
        check_eq("rst_level", btn_level, 0);
        check_eq("rst_long", long_press, 0);
        tick(2);
        check_eq("rst_level2", btn_level, 0);

        // Button held through reset counts as a fresh press.
        reset = 1'b0;
        press(12, 1'b0);

        // Clean press, glitches and acceptance boundary.
        press(20, 1'b0);
        press(3, 1'b0);
        press(D, 1'b0);
        press(D + 1, 1'b0);

        // Release bounce and long hold.
        press(12, 1'b1);
        press(30, 1'b0);

        // Back-to-back presses with 10 low cycles between.
        press(8, 1'b0);
        tick(3);
        press(8, 1'b0);

        // Reset during PRESS_WAIT aborts the count; held button restarts after release of reset.
        btn_raw = 1'b1;
        tick(D);
        reset = 1'b1;
        tick(2);
        check_eq("midrst_level", btn_level, 0);
        reset = 1'b0;
        press(12, 1'b0);

        // Reset while pressed clears the level and cancels any pending long press.
        start_q.push_back(cyc + 3 + D);
        btn_raw = 1'b1;
        tick(10);
        check_eq("pressed_level", btn_level, 1);
        reset = 1'b1;
        tick(1);
        check_eq("rst_pressed_level", btn_level, 0);
        tick(1);
        btn_raw = 1'b0;
        reset   = 1'b0;
        tick(3 + D + 6);
        check_eq("post_rst_level", btn_level, 0);

        tick(5);
        check_eq("start_left", start_q.size(), 0);
        check_eq("long_left", long_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
